lut_coef_loader: RTL and testbench
==================================

# lut_coef_loader

- Builds the 64-entry coefficient table that the 8-bit quadratic-interpolation LUT evaluator reads.
- Accepts a full 256-sample function table as a valid/ready byte stream and keeps every 4th sample (index 4j → entry j).
- Precomputes per-entry first and second differences with 6-bit wrap-around neighbours.
- Serves base/difference triples through a registered read port to the evaluator.

## Interface

Parameters:
- none; sizes are fixed by the shared package.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to (re)load the table.
- s_valid  in  1  input sample valid.
- s_data  in  8  input sample, unsigned; samples arrive in index order 0..255.
- s_ready  out  1  loader accepts a sample this cycle.
- busy  out  1  high in LOAD or COEF.
- done  out  1  one-cycle pulse when the table becomes valid.
- table_valid  out  1  level; coefficient table is complete and readable.
- rd_en  in  1  read request.
- rd_addr  in  6  entry index j (X_MSB).
- rd_valid  out  1  read data valid, one cycle after rd_en.
- rd_base  out  8  F[j], unsigned.
- rd_d1  out  9  signed F[j] − F[j−1].
- rd_d2  out  10  signed F[j−1] − 2·F[j] + F[j+1].

## Operation

- **States:** IDLE, LOAD, COEF, READY.
  - Reset → IDLE. In IDLE and READY, `start` → LOAD and clears `table_valid`.
- **LOAD:**
  - `s_ready` = 1.
  - A beat is accepted when `s_valid && s_ready`; the 8-bit sample counter increments only on acceptance.
  - Accepted sample i with i[1:0] = 00 is written to F[i>>2]; the other samples are discarded.
  - After the beat with i = 255 is accepted → COEF, and the counter wraps to 0.
- **COEF:**
  - 64 cycles, with j = 0..63, one entry per cycle.
  - Computes d1[j] and d2[j] from F[j−1], F[j], F[j+1]. Indices are mod 64: j = 0 uses F[63]; j = 63 uses F[0].
  - Arithmetic is sign-extended to 10 bits, so there is no truncation (d1 ∈ [−255,255], d2 ∈ [−510,510]).
  - After j = 63 → READY.
- **READY:** `table_valid` = 1. A `done` pulse is asserted in the first READY cycle only.
- **Reads:**
  - Honoured only while `table_valid` = 1.
  - `rd_en` at any other time produces `rd_valid` = 0, and the rd_* data holds its previous value.
- `start` in LOAD or COEF is ignored; it is not queued.
- `s_valid` outside LOAD is ignored (`s_ready` = 0).
- **Reset mid-operation:** returns to IDLE with `table_valid` = 0. F/d1/d2 storage is not cleared, and a full reload is required.

## Timing

- **Reset values:** `s_ready` 0, `busy` 0, `done` 0, `table_valid` 0, `rd_valid` 0, `rd_base` 0, `rd_d1` 0, `rd_d2` 0.
- `start` sampled high at edge N → LOAD at N+1; `s_ready` is high from cycle N+1.
- **Minimum load time** (`s_valid` held high): 256 cycles of LOAD + 64 cycles of COEF.
  - `done` and `table_valid` rise 320 cycles after the first LOAD cycle.
- **Backpressure:** none on the sink side. Gaps in `s_valid` stall the counter only.
- **Read latency:** 1 cycle. `rd_en`/`rd_addr` sampled at edge N → `rd_valid` and data are valid after edge N+1.
  - Back-to-back reads are sustained at 1 per cycle.
- `start` in READY drops `table_valid` on the next edge. A read issued in that same cycle still completes (sampled while valid).

## Structure

- **Package `lut_pkg`:**
  - Constants: `LUT_FULL` = 256, `LUT_ENTRIES` = 64, `DEC_SHIFT` = 2, `SAMPLE_W` = 8, `D1_W` = 9, `D2_W` = 10.
  - The state enum type.
- **Sub-module `lut_coef_calc`:** purely combinational.
  - Inputs: (F[j−1], F[j], F[j+1]).
  - Outputs: (d1, d2).
  - Reused by the verification reference model.
- **Storage:** three 64-deep register arrays (F, d1, d2). Single clock domain.

## Test plan

- **Ramp:**
  - Stimulus: `start`, then s_data = i mod 256 streamed back-to-back.
  - Timing: `done` 320 cycles after the first LOAD cycle.
  - Read j = 5 → base 20, d1 4, d2 0.
  - Read j = 0 → base 0, d1 −252, d2 256.
  - Read j = 63 → base 252, d1 4, d2 −256.
- **Backpressure gaps:** ramp with `s_valid` low every 3rd cycle → identical table contents, and `done` delayed by exactly the number of gap cycles.
- **Constant table:** all samples 0x80 → every entry base 128, d1 0, d2 0. `rd_valid` follows `rd_en` by 1 cycle for 64 consecutive reads.
- **Ignored requests:**
  - `start` pulsed mid-LOAD at sample 100 → load unaffected, single `done`.
  - `rd_en` before `table_valid` → `rd_valid` stays 0.
- **Reset mid-COEF:** assert `rst` at COEF j = 30 → all outputs take reset values immediately (async). A subsequent full reload produces a correct table.
- **Reload from READY:** `start` in READY with a new table (samples 255−i) → `table_valid` low next cycle. After reload, j = 1 → base 251, d1 −4, d2 0.

Source files
------------

// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared sizes, state encoding and helpers for the LUT coefficient loader
package lut_pkg;

  localparam int LUT_FULL    = 256;
  localparam int LUT_ENTRIES = 64;
  localparam int DEC_SHIFT   = 2;
  localparam int SAMPLE_W    = 8;
  localparam int D1_W        = 9;
  localparam int D2_W        = 10;
  localparam int CNT_W       = $clog2(LUT_FULL);
  localparam int IDX_W       = $clog2(LUT_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COEF  = 2'd2,
    ST_READY = 2'd3
  } lut_state_e;

  // Only every (1 << DEC_SHIFT)-th sample of the full table is kept.
  function automatic logic keep_sample(input logic [CNT_W-1:0] idx);
    return idx[DEC_SHIFT-1:0] == '0;
  endfunction

  function automatic logic [IDX_W-1:0] entry_of(input logic [CNT_W-1:0] idx);
    return idx[CNT_W-1:DEC_SHIFT];
  endfunction

endpackage

// File: rtl/lut_coef_loader_if.sv
// rtl/lut_coef_loader_if.sv - sample stream, control and read port of the coefficient loader
interface lut_coef_loader_if;
  import lut_pkg::*;

  logic                       start;
  logic                       s_valid;
  logic [SAMPLE_W-1:0]        s_data;
  logic                       s_ready;
  logic                       busy;
  logic                       done;
  logic                       table_valid;
  logic                       rd_en;
  logic [IDX_W-1:0]           rd_addr;
  logic                       rd_valid;
  logic [SAMPLE_W-1:0]        rd_base;
  logic signed [D1_W-1:0]     rd_d1;
  logic signed [D2_W-1:0]     rd_d2;

  modport master (
    output start, s_valid, s_data, rd_en, rd_addr,
    input  s_ready, busy, done, table_valid, rd_valid, rd_base, rd_d1, rd_d2
  );

  modport slave (
    input  start, s_valid, s_data, rd_en, rd_addr,
    output s_ready, busy, done, table_valid, rd_valid, rd_base, rd_d1, rd_d2
  );

endinterface

// File: rtl/lut_coef_calc.sv
// rtl/lut_coef_calc.sv - first and second differences of one entry from its wrap-around neighbours
module lut_coef_calc
  import lut_pkg::*;
(
  input  logic [SAMPLE_W-1:0]    f_prev,
  input  logic [SAMPLE_W-1:0]    f_cur,
  input  logic [SAMPLE_W-1:0]    f_next,
  output logic signed [D1_W-1:0] d1,
  output logic signed [D2_W-1:0] d2
);

  logic signed [D1_W-1:0] prev_9, cur_9;
  logic signed [D2_W-1:0] prev_10, cur_10, next_10;

  // Zero-extend the unsigned samples so the signed results never truncate.
  assign prev_9  = $signed({1'b0, f_prev});
  assign cur_9   = $signed({1'b0, f_cur});
  assign prev_10 = $signed({{(D2_W-SAMPLE_W){1'b0}}, f_prev});
  assign cur_10  = $signed({{(D2_W-SAMPLE_W){1'b0}}, f_cur});
  assign next_10 = $signed({{(D2_W-SAMPLE_W){1'b0}}, f_next});

  assign d1 = cur_9 - prev_9;
  assign d2 = prev_10 - (cur_10 <<< 1) + next_10;

endmodule

// File: rtl/lut_coef_loader.sv
// rtl/lut_coef_loader.sv - decimates a 256-sample stream into a 64-entry base/d1/d2 table with a registered read port
module lut_coef_loader
  import lut_pkg::*;
(
  input logic               clk,
  input logic               rst,
  lut_coef_loader_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_COEF  = ST_COEF;
  localparam logic [1:0] S_READY = ST_READY;

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(LUT_FULL - 1);
  localparam logic [IDX_W-1:0] LAST_ENTRY  = IDX_W'(LUT_ENTRIES - 1);

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   done_r;
  logic                   table_valid_r;

  logic [SAMPLE_W-1:0]    f_mem  [LUT_ENTRIES];
  logic signed [D1_W-1:0] d1_mem [LUT_ENTRIES];
  logic signed [D2_W-1:0] d2_mem [LUT_ENTRIES];

  logic                   rd_valid_r;
  logic [SAMPLE_W-1:0]    rd_base_r;
  logic signed [D1_W-1:0] rd_d1_r;
  logic signed [D2_W-1:0] rd_d2_r;

  logic                   accept;
  logic                   rd_hit;
  logic [IDX_W-1:0]       j_cur, j_prev, j_next;
  logic signed [D1_W-1:0] calc_d1;
  logic signed [D2_W-1:0] calc_d2;

  assign accept = (state == S_LOAD) && bus.s_valid;
  assign rd_hit = bus.rd_en && table_valid_r;

  // During COEF the low bits of the sample counter walk the entries; 6-bit arithmetic gives the wrap.
  assign j_cur  = cnt[IDX_W-1:0];
  assign j_prev = j_cur - IDX_W'(1);
  assign j_next = j_cur + IDX_W'(1);

  lut_coef_calc u_calc (
    .f_prev (f_mem[j_prev]),
    .f_cur  (f_mem[j_cur]),
    .f_next (f_mem[j_next]),
    .d1     (calc_d1),
    .d2     (calc_d2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      done_r        <= 1'b0;
      table_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE, S_READY: begin
          if (bus.start) begin
            state         <= S_LOAD;
            cnt           <= '0;
            table_valid_r <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_SAMPLE) begin
              state <= S_COEF;
            end
          end
        end
        S_COEF: begin
          if (j_cur == LAST_ENTRY) begin
            state         <= S_READY;
            cnt           <= '0;
            done_r        <= 1'b1;
            table_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Table storage is deliberately left out of reset; a reload rebuilds every entry.
  always_ff @(posedge clk) begin
    if (accept && keep_sample(cnt)) begin
      f_mem[entry_of(cnt)] <= bus.s_data;
    end
    if (state == S_COEF) begin
      d1_mem[j_cur] <= calc_d1;
      d2_mem[j_cur] <= calc_d2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_base_r  <= '0;
      rd_d1_r    <= '0;
      rd_d2_r    <= '0;
    end else begin
      rd_valid_r <= rd_hit;
      if (rd_hit) begin
        rd_base_r <= f_mem[bus.rd_addr];
        rd_d1_r   <= d1_mem[bus.rd_addr];
        rd_d2_r   <= d2_mem[bus.rd_addr];
      end
    end
  end

  assign bus.s_ready     = (state == S_LOAD);
  assign bus.busy        = (state == S_LOAD) || (state == S_COEF);
  assign bus.done        = done_r;
  assign bus.table_valid = table_valid_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_base     = rd_base_r;
  assign bus.rd_d1       = rd_d1_r;
  assign bus.rd_d2       = rd_d2_r;

endmodule

// File: tb/tb_lut_coef_loader.sv
// tb/tb_lut_coef_loader.sv - randomized self-checking bench for lut_coef_loader
module tb_lut_coef_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int   stim [256];
  int   ref_f [64];

  lut_coef_loader_if bus ();

  lut_coef_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int m_d1(input int j);
    return ref_f[j] - ref_f[(j + 63) % 64];
  endfunction

  function automatic int m_d2(input int j);
    return ref_f[(j + 63) % 64] - 2 * ref_f[j] + ref_f[(j + 1) % 64];
  endfunction

  task automatic read_one(input int j, input int eb, input int ed1, input int ed2, input string name);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'(j);
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || int'(bus.rd_base) !== eb ||
        int'($signed(bus.rd_d1)) !== ed1 || int'($signed(bus.rd_d2)) !== ed2) begin
      errors++;
      $display("FAIL %s: got v=%0b base=%0d d1=%0d d2=%0d want v=1 base=%0d d1=%0d d2=%0d",
               name, bus.rd_valid, bus.rd_base, $signed(bus.rd_d1), $signed(bus.rd_d2), eb, ed1, ed2);
    end
  endtask

  task automatic read_all(input string name);
    for (int k = 0; k < 64; k++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'(k);
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || int'(bus.rd_base) !== ref_f[k] ||
          int'($signed(bus.rd_d1)) !== m_d1(k) || int'($signed(bus.rd_d2)) !== m_d2(k)) begin
        errors++;
        $display("FAIL %s[%0d]: got v=%0b base=%0d d1=%0d d2=%0d want v=1 base=%0d d1=%0d d2=%0d",
                 name, k, bus.rd_valid, bus.rd_base, $signed(bus.rd_d1), $signed(bus.rd_d2),
                 ref_f[k], m_d1(k), m_d2(k));
      end
    end
    bus.rd_en = 1'b0;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_rd_valid_drop: got %0b want 0", name, bus.rd_valid);
    end
  endtask

  // Streams stim[] and checks load latency, the done pulse and that reads stay dead while loading.
  task automatic do_load(input bit gap_mode, input bit mid_start, input bit chk_read, input string name);
    int lat, acc, gaps, dones, rdv_seen;
    bit v;
    bus.start = 1'b1;
    if (chk_read) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'd7;
    end
    tick();
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    if (chk_read) begin
      checks++;
      if (bus.table_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_tv_drop: got %0b want 0", name, bus.table_valid);
      end
      checks++;
      if (bus.rd_valid !== 1'b1 || int'(bus.rd_base) !== ref_f[7] ||
          int'($signed(bus.rd_d1)) !== m_d1(7) || int'($signed(bus.rd_d2)) !== m_d2(7)) begin
        errors++;
        $display("FAIL %s_read_at_start: got v=%0b base=%0d d1=%0d d2=%0d want v=1 base=%0d d1=%0d d2=%0d",
                 name, bus.rd_valid, bus.rd_base, $signed(bus.rd_d1), $signed(bus.rd_d2),
                 ref_f[7], m_d1(7), m_d2(7));
      end
    end
    checks++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_load_entry: got s_ready=%0b busy=%0b want 1 1", name, bus.s_ready, bus.busy);
    end
    for (int i = 0; i < 64; i++) ref_f[i] = stim[4 * i];

    lat = 0; acc = 0; gaps = 0; dones = 0; rdv_seen = 0;
    while (acc < 256) begin
      v = !(gap_mode && (lat % 3 == 2));
      bus.s_valid = v;
      bus.s_data  = v ? 8'(stim[acc]) : 8'($urandom);
      bus.start   = mid_start && (acc == 100);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'($urandom);
      tick();
      lat++;
      if (v) acc++;
      else gaps++;
      if (bus.done === 1'b1) dones++;
      if (bus.rd_valid !== 1'b0) rdv_seen++;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    while (bus.done !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
      if (bus.rd_valid !== 1'b0) rdv_seen++;
    end
    bus.rd_en = 1'b0;
    checks++;
    if (lat !== 320 + gaps) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d cycles want %0d", name, lat, 320 + gaps);
    end
    checks++;
    if (bus.table_valid !== 1'b1 || bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_state: got tv=%0b busy=%0b s_ready=%0b want 1 0 0",
               name, bus.table_valid, bus.busy, bus.s_ready);
    end
    checks++;
    if (rdv_seen !== 0) begin
      errors++;
      $display("FAIL %s_rd_while_busy: got %0d rd_valid cycles want 0", name, rdv_seen);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || bus.table_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_single_done: got extra_done=%0d tv=%0b want 0 1", name, dones, bus.table_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.s_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.table_valid !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.rd_base !== 8'd0 || bus.rd_d1 !== 9'sd0 || bus.rd_d2 !== 10'sd0) begin
      errors++;
      $display("FAIL %s: got s_ready=%0b busy=%0b done=%0b tv=%0b rdv=%0b base=%0d d1=%0d d2=%0d want all 0",
               name, bus.s_ready, bus.busy, bus.done, bus.table_valid, bus.rd_valid,
               bus.rd_base, bus.rd_d1, bus.rd_d2);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_values");
    rst = 1'b0;
    tick();
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_read_before_valid;
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'($urandom);
      tick();
      if (bus.rd_valid !== 1'b0 || bus.rd_base !== 8'd0) bad++;
    end
    bus.rd_en = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL read_before_valid: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_ramp;
    for (int i = 0; i < 256; i++) stim[i] = i;
    do_load(1'b0, 1'b0, 1'b0, "ramp");
    read_one(5, 20, 4, 0, "ramp_j5");
    read_one(0, 0, -252, 256, "ramp_j0");
    read_one(63, 252, 4, -256, "ramp_j63");
    read_all("ramp_all");
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 256; i++) stim[i] = i;
    do_load(1'b1, 1'b0, 1'b0, "gaps");
    read_all("gaps_all");
  endtask

  task automatic test_constant;
    for (int i = 0; i < 256; i++) stim[i] = 128;
    do_load(1'b0, 1'b0, 1'b0, "const");
    read_one(17, 128, 0, 0, "const_j17");
    read_all("const_all");
  endtask

  task automatic test_mid_start;
    for (int i = 0; i < 256; i++) stim[i] = int'($urandom_range(255, 0));
    do_load(1'b0, 1'b1, 1'b0, "mid_start");
    read_all("mid_start_all");
  endtask

  task automatic test_reset_mid_coef;
    for (int i = 0; i < 256; i++) stim[i] = int'($urandom_range(255, 0));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(stim[i]);
      tick();
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_coef_async");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset_mid_coef_idle");
    for (int i = 0; i < 256; i++) stim[i] = int'($urandom_range(255, 0));
    do_load(1'b1, 1'b0, 1'b0, "after_reset");
    read_all("after_reset_all");
  endtask

  task automatic test_reload;
    for (int i = 0; i < 256; i++) stim[i] = i;
    do_load(1'b0, 1'b0, 1'b0, "pre_reload");
    for (int i = 0; i < 256; i++) stim[i] = 255 - i;
    do_load(1'b0, 1'b0, 1'b1, "reload");
    read_one(1, 251, -4, 0, "reload_j1");
    read_all("reload_all");
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 256; i++) stim[i] = int'($urandom_range(255, 0));
      do_load(t[0], 1'b0, 1'b1, "b2b");
      read_all("b2b_all");
    end
  endtask

  initial begin
    test_reset();
    test_read_before_valid();
    test_ramp();
    test_gaps();
    test_constant();
    test_mid_start();
    test_reset_mid_coef();
    test_reload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
